// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared op codes, FSM state encoding and result-byte count for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_FEED0,
    S_FEED1,
    S_FEED2,
    S_RUN,
    S_ABORT,
    S_RESP
  } state_t;

  // mult/div return two bytes (hi then lo); add/sub return only the low byte
  function automatic logic [1:0] exp_bytes(input logic [1:0] op);
    return op[1] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready bundle between a requester (master) and the sequencer (slave).
interface alu_cmd_sequencer_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_w0;
  logic [W-1:0] cmd_w1;
  logic [W-1:0] cmd_w2;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_hi;
  logic [W-1:0] rsp_lo;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_w0, cmd_w1, cmd_w2, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_w0, cmd_w1, cmd_w2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer_watchdog.sv
// RUN-cycle watchdog: counts while enabled, cleared otherwise, saturating; flags the last allowed cycle.
// On fire it produces an ABORT_RST-cycle reset pulse starting the following cycle.
module alu_watchdog #(
  parameter int TIMEOUT_CYC = 64,
  parameter int ABORT_RST   = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_fire,
  output logic o_timeout,
  output logic o_abort_rst,
  output logic o_abort_last
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(ABORT_RST + 1);

  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_pulse <= '0;
    end else begin
      if (!i_en)
        r_cnt <= '0;
      else if (r_cnt != CW'(TIMEOUT_CYC))
        r_cnt <= r_cnt + CW'(1);

      if (i_fire)
        r_pulse <= PW'(ABORT_RST);
      else if (r_pulse != '0)
        r_pulse <= r_pulse - PW'(1);
    end
  end

  assign o_timeout    = i_en & (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign o_abort_rst  = (r_pulse != '0);
  assign o_abort_last = (r_pulse == PW'(1));
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front-end for the sequential ALU: one command in, begin/operand bytes out in ALU order, result bytes back as one response.
// alu_begin the cycle after accept; cmd_ready stays low until the response is taken; response held until rsp_ready.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W           = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int ABORT_RST   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  alu_cmd_sequencer_if.slave s_cmd,
  output logic               o_alu_rst,
  output logic               o_alu_begin,
  output logic [1:0]         o_alu_op,
  output logic [W-1:0]       o_alu_in,
  input  logic [W-1:0]       i_alu_out,
  input  logic               i_alu_wr,
  input  logic               i_alu_end
);
  state_t       r_state, w_next;
  logic [1:0]   r_op;
  logic [W-1:0] r_w0, r_w1, r_w2;
  logic [W-1:0] r_hi, r_lo;
  logic         r_err;
  logic [1:0]   r_ncap;
  logic [1:0]   w_exp;
  logic         w_cmd_hs, w_rsp_hs, w_cap, w_fire;
  logic         w_timeout, w_abort_rst, w_abort_last;
  logic [W-1:0] w_alu_in;

  assign w_exp    = exp_bytes(r_op);
  assign w_cmd_hs = s_cmd.cmd_valid & s_cmd.cmd_ready;
  assign w_rsp_hs = s_cmd.rsp_valid & s_cmd.rsp_ready;
  assign w_cap    = (r_state == S_RUN) & i_alu_wr & (r_ncap < w_exp);

  alu_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ABORT_RST   (ABORT_RST)
  ) u_watchdog (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (r_state == S_RUN),
    .i_fire       (w_fire),
    .o_timeout    (w_timeout),
    .o_abort_rst  (w_abort_rst),
    .o_abort_last (w_abort_last)
  );

  always_comb begin
    w_next = r_state;
    w_fire = 1'b0;
    case (r_state)
      S_IDLE:  if (w_cmd_hs) w_next = S_BEGIN;
      S_BEGIN: w_next = S_FEED0;
      S_FEED0: w_next = S_FEED1;
      S_FEED1: w_next = (r_op == OP_DIV) ? S_FEED2 : S_RUN;
      S_FEED2: w_next = S_RUN;
      S_RUN: begin
        // alu_end beats a timeout landing on the same cycle
        if (i_alu_end) begin
          w_next = S_RESP;
        end else if (w_timeout) begin
          w_next = S_ABORT;
          w_fire = 1'b1;
        end
      end
      S_ABORT: if (w_abort_last) w_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_alu_in = '0;
    case (r_state)
      S_FEED0: w_alu_in = r_w0;
      S_FEED1: w_alu_in = r_w1;
      S_FEED2: w_alu_in = r_w2;
      default: w_alu_in = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_err   <= 1'b0;
      r_ncap  <= '0;
    end else begin
      r_state <= w_next;
      if (w_cmd_hs) begin
        r_op   <= s_cmd.cmd_op;
        r_w0   <= s_cmd.cmd_w0;
        r_w1   <= s_cmd.cmd_w1;
        r_w2   <= s_cmd.cmd_w2;
        r_hi   <= '0;
        r_lo   <= '0;
        r_err  <= 1'b0;
        r_ncap <= '0;
      end
      if (w_rsp_hs)
        r_op <= OP_ADD;
      if (w_cap) begin
        r_ncap <= r_ncap + 2'd1;
        if (r_op[1] && (r_ncap == 2'd0))
          r_hi <= i_alu_out;
        else
          r_lo <= i_alu_out;
      end
      if ((r_state == S_RUN) && i_alu_end)
        r_err <= ((r_ncap + {1'b0, w_cap}) < w_exp);
      if (w_fire) begin
        r_hi  <= '0;
        r_lo  <= '0;
        r_err <= 1'b1;
      end
    end
  end

  assign s_cmd.cmd_ready = (r_state == S_IDLE) & ~i_rst;
  assign s_cmd.rsp_valid = (r_state == S_RESP);
  assign s_cmd.rsp_hi    = r_hi;
  assign s_cmd.rsp_lo    = r_lo;
  assign s_cmd.rsp_err   = r_err;

  assign o_alu_rst   = i_rst | w_abort_rst;
  assign o_alu_begin = (r_state == S_BEGIN);
  assign o_alu_op    = r_op;
  assign o_alu_in    = w_alu_in;
endmodule
